mvm_load_sequencer: RTL
=======================

MVM_LOAD_SEQUENCER -- requirements
Module: mvm_load_sequencer

Interface
REQ-001 Parameter DATAW, 512, payload width of source and master streams.
REQ-002 Parameter DESTW, 12, router destination width.
REQ-003 Parameter USERW, 75, tuser width: [8:0] RF address, [10:9] opcode, [74:11] one-hot lane select.
REQ-004 Parameter IDW, 32, tid width.
REQ-005 Parameter LANES, 64, weight words per destination; SHALL equal USERW-11.
REQ-006 Ports: CLK in 1 clock; RST in 1 reset. One clock; reset is asynchronous and active-high.
REQ-007 Ports: START in 1 (go pulse); BUSY out 1; DONE out 1 (one-cycle pulse).
REQ-008 Ports: CFG_WDEST_BASE in DESTW; CFG_NUM_WDEST in 8; CFG_RF_ADDR in 9; CFG_VDEST_BASE in DESTW; CFG_NUM_VEC in 4; CFG_INST_DEST in DESTW; CFG_INST_WORD in 32.
REQ-009 Ports: SRC_TVALID in 1; SRC_TREADY out 1; SRC_TDATA in DATAW (weight then vector words, in order).
REQ-010 Ports: AXIS_M_TVALID out 1; AXIS_M_TREADY in 1; AXIS_M_TDATA out DATAW; AXIS_M_TUSER out USERW; AXIS_M_TDEST out DESTW; AXIS_M_TID out IDW (constant 0); AXIS_M_TLAST out 1 (1 on every packet); feeds mvm_top AXIS_S.

Function
REQ-011 States IDLE, WEIGHT, VECTOR, INST, FINISH; BUSY=1 in all but IDLE.
REQ-012 IDLE: START=1 captures all CFG_* inputs; next state WEIGHT if CFG_NUM_WDEST>0, else VECTOR if CFG_NUM_VEC>0, else INST. START while BUSY SHALL be ignored.
REQ-013 Single output register; SRC_TREADY = (state WEIGHT or VECTOR) and (!AXIS_M_TVALID or AXIS_M_TREADY); accepted source word appears on AXIS_M next cycle (latency 1).
REQ-014 AXIS_M_* SHALL hold stable while AXIS_M_TVALID=1 and AXIS_M_TREADY=0.
REQ-015 WEIGHT packet k for lane L, dest index d: TDATA=source word, TUSER[8:0]=RF addr, [10:9]=2'b11, exactly bit 11+L set, TDEST=WDEST_BASE+d modulo 2^DESTW.
REQ-016 Lane counter 0..LANES-1; wrap to 0 increments d; after lane LANES-1 of d=NUM_WDEST-1, go to VECTOR (or INST if NUM_VEC=0).
REQ-017 VECTOR packet v: TDATA=source word, TUSER[10:9]=2'b10, all other TUSER bits 0, TDEST=VDEST_BASE+v; after NUM_VEC packets go to INST.
REQ-018 INST: when output register free, emit one packet TDATA = INST_WORD zero-extended, TUSER=0, TDEST=INST_DEST; state FINISH.
REQ-019 FINISH: once last packet handshaken (TVALID&TREADY), DONE=1 one cycle, return IDLE.
REQ-020 Source stall (SRC_TVALID=0) SHALL insert bubbles without dropping or duplicating packets; phase boundary SHALL not waste a cycle when TREADY=1.

Reset
REQ-021 RST=1 at any time, including mid-packet: state IDLE, counters 0, AXIS_M_TVALID=0, TDATA/TUSER/TDEST/TLAST=0, SRC_TREADY=0, BUSY=0, DONE=0; captured config cleared; in-flight packet discarded.

Configuration
REQ-022 Macro MVM_SEQ_PERF_EN defined: outputs PERF_PKT_COUNT[15:0] (handshaken packets) and PERF_STALL_COUNT[15:0] (cycles TVALID=1,TREADY=0), saturating at 16'hFFFF, cleared on reset and on accepted START.
REQ-023 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-024 NUM_WDEST=2, base 12'h001, RF 9'h1, TREADY=1, 128 source words -> 128 packets, dest 001 lanes 0..63 then 002, TUSER[10:9]=11, one-hot bit 11+L.
REQ-025 NUM_WDEST=0, NUM_VEC=2, VDEST_BASE 12'h001, INST_WORD 32'hC040_100E, INST_DEST 12'h001 -> vectors to 001,002 (op 10), then instruction packet, DONE pulse.
REQ-026 TREADY toggled 1-0 every cycle during WEIGHT -> no loss/duplication, outputs stable during stalls; with MVM_SEQ_PERF_EN, stall count equals stalled cycles.
REQ-027 SRC_TVALID gaps of 3 cycles -> bubbles only; packet order and lane bits intact.
REQ-028 RST asserted at lane 30 of dest 1 -> all outputs 0 next edge; new START restarts at lane 0, dest base.
REQ-029 WDEST_BASE 12'hFFF, NUM_WDEST=2 -> second dest 12'h000; START pulsed while BUSY -> ignored.

Source files
------------

// File: rtl/mvm_load_sequencer.sv
// Streams weight words, vector words and one instruction word into the MVM AXIS slave port.
// Optional performance counters are built when MVM_SEQ_PERF_EN is defined.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | waiting for START, configuration capture
// WEIGHT  | forwarding weight words, lane-major within each destination
// VECTOR  | forwarding vector words, one destination per word
// INST    | emitting the instruction packet once the output register frees up
// FINISH  | waiting for the instruction packet handshake, then DONE
module mvm_load_sequencer #(
    parameter int DATAW = 512,
    parameter int DESTW = 12,
    parameter int USERW = 75,
    parameter int IDW   = 32,
    parameter int LANES = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    input  logic [DESTW-1:0] CFG_WDEST_BASE,
    input  logic [7:0]       CFG_NUM_WDEST,
    input  logic [8:0]       CFG_RF_ADDR,
    input  logic [DESTW-1:0] CFG_VDEST_BASE,
    input  logic [3:0]       CFG_NUM_VEC,
    input  logic [DESTW-1:0] CFG_INST_DEST,
    input  logic [31:0]      CFG_INST_WORD,
    input  logic             SRC_TVALID,
    output logic             SRC_TREADY,
    input  logic [DATAW-1:0] SRC_TDATA,
    output logic             AXIS_M_TVALID,
    input  logic             AXIS_M_TREADY,
    output logic [DATAW-1:0] AXIS_M_TDATA,
    output logic [USERW-1:0] AXIS_M_TUSER,
    output logic [DESTW-1:0] AXIS_M_TDEST,
    output logic [IDW-1:0]   AXIS_M_TID,
    output logic             AXIS_M_TLAST
`ifdef MVM_SEQ_PERF_EN
    ,
    output logic [15:0]      PERF_PKT_COUNT,
    output logic [15:0]      PERF_STALL_COUNT
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WEIGHT,
        ST_VECTOR,
        ST_INST,
        ST_FINISH
    } state_t;

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t             state_q, state_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [7:0]         wdest_idx_q, wdest_idx_d;
    logic [3:0]         vec_idx_q, vec_idx_d;

    logic [DESTW-1:0]   wdest_base_q, wdest_base_d;
    logic [7:0]         num_wdest_q, num_wdest_d;
    logic [8:0]         rf_addr_q, rf_addr_d;
    logic [DESTW-1:0]   vdest_base_q, vdest_base_d;
    logic [3:0]         num_vec_q, num_vec_d;
    logic [DESTW-1:0]   inst_dest_q, inst_dest_d;
    logic [31:0]        inst_word_q, inst_word_d;

    logic               m_tvalid_q, m_tvalid_d;
    logic [DATAW-1:0]   m_tdata_q, m_tdata_d;
    logic [USERW-1:0]   m_tuser_q, m_tuser_d;
    logic [DESTW-1:0]   m_tdest_q, m_tdest_d;
    logic               m_tlast_q, m_tlast_d;
    logic               done_q, done_d;

    logic               out_free;
    logic               out_fire;
    logic               src_ready;
    logic               src_fire;
    logic [LANES-1:0]   lane_onehot;

    assign out_free    = !m_tvalid_q || AXIS_M_TREADY;
    assign out_fire    = m_tvalid_q && AXIS_M_TREADY;
    assign src_ready   = ((state_q == ST_WEIGHT) || (state_q == ST_VECTOR)) && out_free;
    assign src_fire    = src_ready && SRC_TVALID;
    assign lane_onehot = {{(LANES-1){1'b0}}, 1'b1} << lane_q;

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        wdest_idx_d  = wdest_idx_q;
        vec_idx_d    = vec_idx_q;
        wdest_base_d = wdest_base_q;
        num_wdest_d  = num_wdest_q;
        rf_addr_d    = rf_addr_q;
        vdest_base_d = vdest_base_q;
        num_vec_d    = num_vec_q;
        inst_dest_d  = inst_dest_q;
        inst_word_d  = inst_word_q;
        m_tvalid_d   = m_tvalid_q;
        m_tdata_d    = m_tdata_q;
        m_tuser_d    = m_tuser_q;
        m_tdest_d    = m_tdest_q;
        m_tlast_d    = m_tlast_q;
        done_d       = 1'b0;

        // A handshake empties the register; a load below in the same cycle refills it.
        if (out_fire) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    wdest_base_d = CFG_WDEST_BASE;
                    num_wdest_d  = CFG_NUM_WDEST;
                    rf_addr_d    = CFG_RF_ADDR;
                    vdest_base_d = CFG_VDEST_BASE;
                    num_vec_d    = CFG_NUM_VEC;
                    inst_dest_d  = CFG_INST_DEST;
                    inst_word_d  = CFG_INST_WORD;
                    lane_d       = '0;
                    wdest_idx_d  = '0;
                    vec_idx_d    = '0;
                    if (CFG_NUM_WDEST != 8'd0) begin
                        state_d = ST_WEIGHT;
                    end else if (CFG_NUM_VEC != 4'd0) begin
                        state_d = ST_VECTOR;
                    end else begin
                        state_d = ST_INST;
                    end
                end
            end
            ST_WEIGHT: begin
                if (src_fire) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = SRC_TDATA;
                    m_tuser_d  = {lane_onehot, 2'b11, rf_addr_q};
                    m_tdest_d  = wdest_base_q + DESTW'(wdest_idx_q);
                    m_tlast_d  = 1'b1;
                    lane_d     = lane_q + LANE_W'(1);
                    if (lane_q == LAST_LANE) begin
                        lane_d = '0;
                        if (wdest_idx_q == num_wdest_q - 8'd1) begin
                            wdest_idx_d = '0;
                            state_d     = (num_vec_q != 4'd0) ? ST_VECTOR : ST_INST;
                        end else begin
                            wdest_idx_d = wdest_idx_q + 8'd1;
                        end
                    end
                end
            end
            ST_VECTOR: begin
                if (src_fire) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = SRC_TDATA;
                    m_tuser_d  = {{(USERW-11){1'b0}}, 2'b10, 9'd0};
                    m_tdest_d  = vdest_base_q + DESTW'(vec_idx_q);
                    m_tlast_d  = 1'b1;
                    if (vec_idx_q == num_vec_q - 4'd1) begin
                        vec_idx_d = '0;
                        state_d   = ST_INST;
                    end else begin
                        vec_idx_d = vec_idx_q + 4'd1;
                    end
                end
            end
            ST_INST: begin
                if (out_free) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = {{(DATAW-32){1'b0}}, inst_word_q};
                    m_tuser_d  = '0;
                    m_tdest_d  = inst_dest_q;
                    m_tlast_d  = 1'b1;
                    state_d    = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (out_fire) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            lane_q       <= '0;
            wdest_idx_q  <= '0;
            vec_idx_q    <= '0;
            wdest_base_q <= '0;
            num_wdest_q  <= '0;
            rf_addr_q    <= '0;
            vdest_base_q <= '0;
            num_vec_q    <= '0;
            inst_dest_q  <= '0;
            inst_word_q  <= '0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tuser_q    <= '0;
            m_tdest_q    <= '0;
            m_tlast_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            wdest_idx_q  <= wdest_idx_d;
            vec_idx_q    <= vec_idx_d;
            wdest_base_q <= wdest_base_d;
            num_wdest_q  <= num_wdest_d;
            rf_addr_q    <= rf_addr_d;
            vdest_base_q <= vdest_base_d;
            num_vec_q    <= num_vec_d;
            inst_dest_q  <= inst_dest_d;
            inst_word_q  <= inst_word_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tuser_q    <= m_tuser_d;
            m_tdest_q    <= m_tdest_d;
            m_tlast_q    <= m_tlast_d;
            done_q       <= done_d;
        end
    end

    assign BUSY          = (state_q != ST_IDLE);
    assign DONE          = done_q;
    assign SRC_TREADY    = src_ready;
    assign AXIS_M_TVALID = m_tvalid_q;
    assign AXIS_M_TDATA  = m_tdata_q;
    assign AXIS_M_TUSER  = m_tuser_q;
    assign AXIS_M_TDEST  = m_tdest_q;
    assign AXIS_M_TID    = '0;
    assign AXIS_M_TLAST  = m_tlast_q;

`ifdef MVM_SEQ_PERF_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        pkt_cnt_d   = pkt_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_IDLE) && START) begin
            pkt_cnt_d   = '0;
            stall_cnt_d = '0;
        end else begin
            if (out_fire && (pkt_cnt_q != 16'hFFFF)) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
            if (m_tvalid_q && !AXIS_M_TREADY && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PERF_PKT_COUNT   = pkt_cnt_q;
    assign PERF_STALL_COUNT = stall_cnt_q;
`endif

endmodule
